// File: rtl/mesi_ctrl.sv
// mesi_ctrl: per-command MESI sequencer between the trace front end,
// the tag/state array and the shared bus, with L1 hit/miss statistics.
module mesi_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [3:0]       cmd,
  output logic             cmd_ready,
  output logic             lookup_en,
  input  logic             line_hit,
  input  logic [1:0]       line_state,
  output logic             state_we,
  output logic [1:0]       state_wdata,
  output logic             bus_req,
  output logic [1:0]       bus_op,
  input  logic             bus_ack,
  input  logic [1:0]       snoop_in,
  output logic             snp_resp_valid,
  output logic [1:0]       snp_resp,
  output logic             clear_all,
  output logic             print_req,
  output logic             cmd_err,
  output logic             done,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_I = 2'b11;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;

  localparam logic [1:0] SNP_NOHIT = 2'b00;
  localparam logic [1:0] SNP_HIT   = 2'b01;
  localparam logic [1:0] SNP_HITM  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, DECIDE, BUS, SNP_RESP, WRBACK, UPDATE
  } state_t;

  state_t     state;
  logic [3:0] cmdQ;
  logic [1:0] effQ, nxtQ;
  logic       errQ, wbQ;

  logic [1:0] eff, dNext, dOp, dResp, rdNext, busNext;
  logic       dBus, dSnp, dWb, dErr;

  assign eff     = line_hit ? line_state : MESI_I;
  assign rdNext  = (snoop_in == SNP_HIT || snoop_in == SNP_HITM) ? MESI_S : MESI_E;
  assign busNext = (bus_op == OP_READ) ? rdNext : nxtQ;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    dBus  = 1'b0;
    dOp   = OP_READ;
    dSnp  = 1'b0;
    dResp = SNP_NOHIT;
    dWb   = 1'b0;
    dNext = eff;
    dErr  = 1'b0;
    unique case (cmdQ)
      4'd0, 4'd2: dBus = (eff == MESI_I);
      4'd1: begin
        dNext = MESI_M;
        dBus  = (eff == MESI_S) || (eff == MESI_I);
        dOp   = (eff == MESI_S) ? OP_INV : OP_RWIM;
      end
      4'd3: begin
        dSnp = 1'b1;
        if (eff == MESI_S) begin
          dResp = SNP_HIT;
          dNext = MESI_I;
        end else if (eff != MESI_I) begin
          dErr = 1'b1;
        end
      end
      4'd4, 4'd6: begin
        dSnp = 1'b1;
        if (eff != MESI_I) begin
          dResp = (eff == MESI_M) ? SNP_HITM : SNP_HIT;
          dWb   = (eff == MESI_M);
          dNext = (cmdQ == 4'd4) ? MESI_S : MESI_I;
        end
      end
      4'd5: dSnp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cmdQ           <= '0;
      effQ           <= '0;
      nxtQ           <= '0;
      errQ           <= 1'b0;
      wbQ            <= 1'b0;
      cmd_ready      <= 1'b0;
      lookup_en      <= 1'b0;
      state_we       <= 1'b0;
      state_wdata    <= '0;
      bus_req        <= 1'b0;
      bus_op         <= '0;
      snp_resp_valid <= 1'b0;
      snp_resp       <= '0;
      clear_all      <= 1'b0;
      print_req      <= 1'b0;
      cmd_err        <= 1'b0;
      done           <= 1'b0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      lookup_en      <= 1'b0;
      state_we       <= 1'b0;
      snp_resp_valid <= 1'b0;
      clear_all      <= 1'b0;
      print_req      <= 1'b0;
      cmd_err        <= 1'b0;
      done           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmdQ      <= cmd;
            cmd_ready <= 1'b0;
            if (cmd <= 4'd6) begin
              state     <= LOOKUP;
              lookup_en <= 1'b1;
            end else begin
              state     <= UPDATE;
              done      <= 1'b1;
              clear_all <= (cmd == 4'd8);
              print_req <= (cmd == 4'd9);
              cmd_err   <= (cmd != 4'd8) && (cmd != 4'd9);
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        LOOKUP: state <= DECIDE;
        DECIDE: begin
          effQ <= eff;
          nxtQ <= dNext;
          errQ <= dErr;
          wbQ  <= dWb;
          if (dBus) begin
            state   <= BUS;
            bus_req <= 1'b1;
            bus_op  <= dOp;
          end else if (dSnp) begin
            state          <= SNP_RESP;
            snp_resp_valid <= 1'b1;
            snp_resp       <= dResp;
          end else begin
            state       <= UPDATE;
            done        <= 1'b1;
            state_we    <= !dErr && (dNext != eff);
            state_wdata <= dNext;
            cmd_err     <= dErr;
          end
        end
        SNP_RESP: begin
          if (wbQ) begin
            state   <= WRBACK;
            bus_req <= 1'b1;
            bus_op  <= OP_WRITE;
          end else begin
            state       <= UPDATE;
            done        <= 1'b1;
            state_we    <= !errQ && (nxtQ != effQ);
            state_wdata <= nxtQ;
            cmd_err     <= errQ;
          end
        end
        BUS, WRBACK: begin
          if (bus_req && bus_ack) begin
            bus_req     <= 1'b0;
            state       <= UPDATE;
            done        <= 1'b1;
            state_we    <= (busNext != effQ);
            state_wdata <= busNext;
          end
        end
        UPDATE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          if (cmdQ == 4'd8) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
          end else if (cmdQ <= 4'd2) begin
            if (cmdQ == 4'd1) wr_cnt <= sat(wr_cnt);
            else              rd_cnt <= sat(rd_cnt);
            if (effQ != MESI_I) hit_cnt  <= sat(hit_cnt);
            else                miss_cnt <= sat(miss_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_ctrl.sv
// tb_mesi_ctrl: randomized and directed checks of mesi_ctrl against a
// transaction-level MESI model with a per-cycle output compare.
module tb_mesi_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst, cmd_valid, cmd_ready, lookup_en, line_hit;
  logic [3:0]    cmd;
  logic [1:0]    line_state, state_wdata, bus_op, snoop_in, snp_resp;
  logic          state_we, bus_req, bus_ack, snp_resp_valid;
  logic          clear_all, print_req, cmd_err, done;
  logic [CW-1:0] rd_cnt, wr_cnt, hit_cnt, miss_cnt;

  mesi_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .lookup_en(lookup_en), .line_hit(line_hit),
    .line_state(line_state), .state_we(state_we),
    .state_wdata(state_wdata), .bus_req(bus_req), .bus_op(bus_op),
    .bus_ack(bus_ack), .snoop_in(snoop_in),
    .snp_resp_valid(snp_resp_valid), .snp_resp(snp_resp),
    .clear_all(clear_all), .print_req(print_req), .cmd_err(cmd_err),
    .done(done), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // expected outputs for the current cycle
  logic       expRdy, expLook, expWe, expReq, expSv;
  logic       expClr, expPrt, expErr, expDone;
  logic [1:0] expWdata, expOp, expResp;
  int         mRd, mWr, mHit, mMiss;
  logic       chkOn = 1'b0;

  // observations used by the literal checks
  int         weSeen = 0, errSeen = 0, clrSeen = 0, prtSeen = 0;
  logic [1:0] lastOp = 2'd3, lastWd = 2'd2, lastResp = 2'd3;

  typedef struct packed {
    logic       bus;
    logic [1:0] op;
    logic       snp;
    logic [1:0] resp;
    logic       wb;
    logic [1:0] nxt;
    logic       err;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    nTests++;
    if (act !== ex) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  // MESI rules: M=0 E=1 S=2 I=3; noHIT=0 HIT=1 HITM=2
  function automatic exp_t model(input logic [3:0] c, input logic [1:0] eff,
                                 input logic [1:0] sIn);
    exp_t r;
    r = '0;
    r.nxt = eff;
    if (c == 0 || c == 2) begin
      if (eff == 3) begin
        r.bus = 1'b1;
        r.op  = 2'd0;
        r.nxt = (sIn == 1 || sIn == 2) ? 2'd2 : 2'd1;
      end
    end else if (c == 1) begin
      r.nxt = 2'd0;
      if (eff == 2) begin r.bus = 1'b1; r.op = 2'd2; end
      if (eff == 3) begin r.bus = 1'b1; r.op = 2'd3; end
    end else if (c >= 3 && c <= 6) begin
      r.snp = 1'b1;
      if ((c == 4 || c == 6) && eff != 3) begin
        r.resp = (eff == 0) ? 2'd2 : 2'd1;
        r.wb   = (eff == 0);
        r.nxt  = (c == 4) ? 2'd2 : 2'd3;
      end
      if (c == 3) begin
        if (eff == 2) begin r.resp = 2'd1; r.nxt = 2'd3; end
        else if (eff != 3) r.err = 1'b1;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus_req) lastOp = bus_op;
    if (snp_resp_valid) lastResp = snp_resp;
    if (state_we) begin lastWd = state_wdata; weSeen++; end
    if (cmd_err) errSeen++;
    if (clear_all) clrSeen++;
    if (print_req) prtSeen++;
    if (chkOn) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(expRdy));
      chk("lookup_en", 32'(lookup_en), 32'(expLook));
      chk("state_we", 32'(state_we), 32'(expWe));
      if (expWe) chk("state_wdata", 32'(state_wdata), 32'(expWdata));
      chk("bus_req", 32'(bus_req), 32'(expReq));
      if (expReq) chk("bus_op", 32'(bus_op), 32'(expOp));
      chk("snp_resp_valid", 32'(snp_resp_valid), 32'(expSv));
      if (expSv) chk("snp_resp", 32'(snp_resp), 32'(expResp));
      chk("clear_all", 32'(clear_all), 32'(expClr));
      chk("print_req", 32'(print_req), 32'(expPrt));
      chk("cmd_err", 32'(cmd_err), 32'(expErr));
      chk("done", 32'(done), 32'(expDone));
      chk("rd_cnt", 32'(rd_cnt), 32'(mRd));
      chk("wr_cnt", 32'(wr_cnt), 32'(mWr));
      chk("hit_cnt", 32'(hit_cnt), 32'(mHit));
      chk("miss_cnt", 32'(miss_cnt), 32'(mMiss));
    end
  end

  task automatic expIdle(input logic rdy);
    expRdy = rdy; expLook = 0; expWe = 0; expReq = 0; expSv = 0;
    expClr = 0; expPrt = 0; expErr = 0; expDone = 0;
    expWdata = 0; expOp = 0; expResp = 0;
  endtask

  function automatic int inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  // next cycle while busy: unaccepted commands and stray acks are noise
  task automatic step();
    @(posedge clk); #1;
    expIdle(1'b0);
    cmd_valid = 1'($urandom_range(0, 1));
    cmd       = 4'($urandom_range(0, 15));
    bus_ack   = 1'($urandom_range(0, 1));
    snoop_in  = 2'($urandom_range(0, 3));
  endtask

  task automatic busPhase(input logic [1:0] op, input int dly,
                          input logic [1:0] sIn);
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) step();
      expReq   = 1'b1;
      expOp    = op;
      bus_ack  = (i == dly);
      snoop_in = sIn;
    end
  endtask

  task automatic finishCmd(input logic [3:0] c, input logic [1:0] eff);
    @(posedge clk); #1;
    expIdle(1'b1);
    cmd_valid = 1'b0;
    bus_ack   = 1'($urandom_range(0, 1));
    if (c == 8) begin
      mRd = 0; mWr = 0; mHit = 0; mMiss = 0;
    end else if (c <= 2) begin
      if (c == 1) mWr = inc(mWr);
      else        mRd = inc(mRd);
      if (eff != 3) mHit = inc(mHit);
      else          mMiss = inc(mMiss);
    end
  endtask

  // starts in an IDLE cycle with cmd_ready high, ends in the next one
  task automatic doCmd(input logic [3:0] c, input logic hit,
                       input logic [1:0] ls, input logic [1:0] sIn,
                       input int dly);
    logic [1:0] eff;
    exp_t r;
    eff = hit ? ls : 2'd3;
    r = model(c, eff, sIn);
    cmd_valid = 1'b1;
    cmd = c;
    step();
    if (c > 6) begin
      expDone = 1'b1;
      expClr  = (c == 8);
      expPrt  = (c == 9);
      expErr  = (c != 8) && (c != 9);
    end else begin
      expLook = 1'b1;
      line_hit = hit;
      line_state = ls;
      step();
      step();
      if (r.bus) begin
        busPhase(r.op, dly, sIn);
        step();
      end else if (r.snp) begin
        expSv = 1'b1;
        expResp = r.resp;
        step();
        if (r.wb) begin
          busPhase(2'd1, dly, 2'($urandom_range(0, 2)));
          step();
        end
      end
      expDone  = 1'b1;
      expWe    = !r.err && (r.nxt != eff);
      expWdata = r.nxt;
      expErr   = r.err;
    end
    finishCmd(c, eff);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int weB, errB, clrB, prtB;
    logic [3:0] c;
    rst = 1'b1; cmd_valid = 0; cmd = 0; line_hit = 0; line_state = 0;
    bus_ack = 0; snoop_in = 0;
    mRd = 0; mWr = 0; mHit = 0; mMiss = 0;
    expIdle(1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chkOn = 1'b1;
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rd_cnt", 32'(rd_cnt), 32'd0);
    @(posedge clk); #1;
    expIdle(1'b1);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    doCmd(4'd0, 1'b0, 2'd0, 2'd0, 3);
    chk("read_miss_op", 32'(lastOp), 32'd0);
    chk("read_miss_wdata", 32'(lastWd), 32'd1);
    chk("read_miss_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("read_miss_miss_cnt", 32'(miss_cnt), 32'd1);

    doCmd(4'd1, 1'b1, 2'd2, 2'd0, 2);
    chk("write_s_op", 32'(lastOp), 32'd2);
    chk("write_s_wdata", 32'(lastWd), 32'd0);
    chk("write_s_hit_cnt", 32'(hit_cnt), 32'd1);

    doCmd(4'd6, 1'b1, 2'd0, 2'd0, 1);
    chk("rfo_m_resp", 32'(lastResp), 32'd2);
    chk("rfo_m_op", 32'(lastOp), 32'd1);
    chk("rfo_m_wdata", 32'(lastWd), 32'd3);

    weB = weSeen; errB = errSeen;
    doCmd(4'd3, 1'b1, 2'd1, 2'd0, 0);
    chk("sinv_e_resp", 32'(lastResp), 32'd0);
    chk("sinv_e_err", 32'(errSeen - errB), 32'd1);
    chk("sinv_e_no_we", 32'(weSeen - weB), 32'd0);

    prtB = prtSeen; errB = errSeen; clrB = clrSeen;
    doCmd(4'd9, 1'b0, 2'd0, 2'd0, 0);
    doCmd(4'd7, 1'b0, 2'd0, 2'd0, 0);
    doCmd(4'd8, 1'b0, 2'd0, 2'd0, 0);
    chk("print_pulse", 32'(prtSeen - prtB), 32'd1);
    chk("illegal_err", 32'(errSeen - errB), 32'd1);
    chk("clear_pulse", 32'(clrSeen - clrB), 32'd1);
    chk("clear_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("clear_wr_cnt", 32'(wr_cnt), 32'd0);

    // reset while a bus read is outstanding
    doCmd(4'd1, 1'b1, 2'd1, 2'd0, 0);
    cmd_valid = 1'b1; cmd = 4'd0;
    step();
    expLook = 1'b1; line_hit = 1'b0;
    step();
    step();
    expReq = 1'b1; expOp = 2'd0; bus_ack = 1'b0;
    #2;
    chkOn = 1'b0;
    weB = weSeen;
    rst = 1'b1;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_state_we", 32'(state_we), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mRd = 0; mWr = 0; mHit = 0; mMiss = 0;
    expIdle(1'b0);
    chkOn = 1'b1;
    @(posedge clk); #1;
    expIdle(1'b1);
    chk("rst_ready_back", 32'(cmd_ready), 32'd1);
    chk("rst_no_we", 32'(weSeen - weB), 32'd0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) c = 4'($urandom_range(0, 6));
      else c = 4'($urandom_range(7, 15));
      doCmd(c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 2)), $urandom_range(0, 4));
    end

    doCmd(4'd8, 1'b0, 2'd0, 2'd0, 0);
    for (int n = 0; n < 18; n++) doCmd(4'd0, 1'b1, 2'd2, 2'd0, 0);
    chk("sat_rd_cnt", 32'(rd_cnt), 32'd15);
    chk("sat_hit_cnt", 32'(hit_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
